// File: rtl/hamming_codec_pipe_pkg.sv
// Package hamming_pkg: code geometry helpers and the transaction mode type
// shared by the Hamming codec pipeline, its interface users and its core.
//   par_w(data_w)        number of Hamming parity bits for data_w data bits
//   code_w(data_w, sd)   full codeword width including the optional overall bit
//   is_pow2(p)           true for parity positions (1, 2, 4, ...)
//   data_idx(p)          rank of data position p among data positions (0 = MSB)
package hamming_pkg;

  typedef enum logic {
    MODE_ENC = 1'b0,
    MODE_DEC = 1'b1
  } mode_e;

  function automatic int par_w(input int data_w);
    for (int r = 1; r < 8; r++) begin
      if ((1 << r) >= data_w + r + 1) return r;
    end
    return 7;
  endfunction

  function automatic int code_w(input int data_w, input int secded);
    return data_w + par_w(data_w) + secded;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order,
  // MSB first, so the rank of a position is the count of data positions below it.
  function automatic int data_idx(input int p);
    int n;
    n = 0;
    for (int q = 1; q < p; q++) begin
      if (!is_pow2(q)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/hamming_codec_pipe_if.sv
// Stream interface of the Hamming codec pipeline: input side (valid/ready,
// mode, word) and output side (valid/ready, word, mode, correction flags).
//   master: producer/consumer view (drives inputs and out_ready)
//   slave : codec view (drives in_ready and all out_* results)
interface hamming_codec_pipe_if #(
  parameter int CODE_W = 13
);
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_word;
  logic              out_mode;
  logic              out_corr;
  logic              out_uncorr;

  modport master (
    output in_valid, in_mode, in_word, out_ready,
    input  in_ready, out_valid, out_word, out_mode, out_corr, out_uncorr
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready,
    output in_ready, out_valid, out_word, out_mode, out_corr, out_uncorr
  );
endinterface

// File: rtl/hamming_codec_pipe_core.sv
// hamming_core: combinational datapath of the codec, split across the two
// pipeline stages.
//   Front half (before S1): rawMode/rawWord -> stageWord (codeword with parity
//     slots zero for encode, received word for decode), stageSyn, stageG.
//   Back half (before S2): s1Mode/s1Word/s1Syn/s1G -> resWord, resCorr, resUncorr.
// Encode reuses the syndrome unit: with parity slots cleared, the syndrome of
// the spread data word equals the parity bits that must be inserted.
module hamming_core
  import hamming_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int SECDED = 1,
  localparam int PAR_W  = par_w(DATA_W),
  localparam int CODE_W = code_w(DATA_W, SECDED)
) (
  input  logic              rawMode,
  input  logic [CODE_W-1:0] rawWord,
  output logic [CODE_W-1:0] stageWord,
  output logic [PAR_W-1:0]  stageSyn,
  output logic              stageG,
  input  logic              s1Mode,
  input  logic [CODE_W-1:0] s1Word,
  input  logic [PAR_W-1:0]  s1Syn,
  input  logic              s1G,
  output logic [CODE_W-1:0] resWord,
  output logic              resCorr,
  output logic              resUncorr
);
  localparam int N = DATA_W + PAR_W;

  logic [CODE_W-1:0] fixedWord;
  logic [DATA_W-1:0] dataOut;
  logic              synInRange;

  always_comb begin
    stageWord = '0;
    stageSyn  = '0;
    if (mode_e'(rawMode) == MODE_DEC) begin
      stageWord = rawWord;
    end else begin
      for (int p = 1; p <= N; p++) begin
        if (!is_pow2(p)) stageWord[CODE_W-p] = rawWord[DATA_W-1-data_idx(p)];
      end
    end
    for (int p = 1; p <= N; p++) begin
      if (stageWord[CODE_W-p]) stageSyn = stageSyn ^ PAR_W'(p);
    end
    stageG = ^stageWord;
  end

  always_comb begin
    resWord    = '0;
    resCorr    = 1'b0;
    resUncorr  = 1'b0;
    fixedWord  = s1Word;
    dataOut    = '0;
    synInRange = (s1Syn != '0) && (int'(s1Syn) <= N);
    if (mode_e'(s1Mode) == MODE_ENC) begin
      resWord = s1Word;
      for (int k = 0; k < PAR_W; k++) resWord[CODE_W-(1<<k)] = s1Syn[k];
      // Overall bit covers data and parity: data parity is s1G, parity-bit parity is ^s1Syn.
      if (SECDED != 0) resWord[0] = s1G ^ (^s1Syn);
    end else begin
      if (SECDED == 0) begin
        if (s1Syn != '0) begin
          resCorr   = synInRange;
          resUncorr = !synInRange;
        end
      end else begin
        if (s1G) begin
          if (s1Syn == '0) begin
            fixedWord[0] = ~fixedWord[0];
            resCorr      = 1'b1;
          end else begin
            resCorr   = synInRange;
            resUncorr = !synInRange;
          end
        end else if (s1Syn != '0) begin
          resUncorr = 1'b1;
        end
      end
      if (resCorr) begin
        for (int p = 1; p <= N; p++) begin
          if (int'(s1Syn) == p) fixedWord[CODE_W-p] = ~fixedWord[CODE_W-p];
        end
      end
      for (int p = 1; p <= N; p++) begin
        if (!is_pow2(p)) dataOut[DATA_W-1-data_idx(p)] = fixedWord[CODE_W-p];
      end
      resWord = CODE_W'(dataOut);
    end
  end

endmodule

// File: rtl/hamming_codec_pipe.sv
// hamming_codec_pipe: two-stage pipelined Hamming encoder/decoder with
// valid/ready on both sides and saturating correction statistics.
//   clk, rst      single clock, synchronous active-high reset
//   bus (slave)   in_valid/in_ready/in_mode/in_word, out_valid/out_ready/
//                 out_word/out_mode/out_corr/out_uncorr
//   cnt_clear     synchronous clear of both counters (wins over increment)
//   cnt_corr      corrected results delivered, saturating
//   cnt_uncorr    uncorrectable results delivered, saturating
// S1 holds the input word with its syndrome and parity; S2 holds the final
// result. in_ready looks at out_ready combinationally so a full pipeline
// keeps streaming one word per cycle.
module hamming_codec_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  hamming_codec_pipe_if.slave bus,
  input  logic                cnt_clear,
  output logic [CNT_W-1:0]    cnt_corr,
  output logic [CNT_W-1:0]    cnt_uncorr
);
  localparam int PAR_W  = par_w(DATA_W);
  localparam int CODE_W = code_w(DATA_W, SECDED);

  logic              s1Valid, s1Mode, s1G;
  logic [CODE_W-1:0] s1Word;
  logic [PAR_W-1:0]  s1Syn;
  logic [CODE_W-1:0] stageWord;
  logic [PAR_W-1:0]  stageSyn;
  logic              stageG;
  logic [CODE_W-1:0] resWord;
  logic              resCorr, resUncorr;
  logic              s2Valid, s2Mode, s2Corr, s2Uncorr;
  logic [CODE_W-1:0] s2Word;
  logic              s2Load, s1Advance, inReady, inXfer, outXfer;

  assign s2Load    = !s2Valid || bus.out_ready;
  assign s1Advance = s1Valid && s2Load;
  assign inReady   = !s1Valid || s1Advance;
  assign inXfer    = bus.in_valid && inReady;
  assign outXfer   = s2Valid && bus.out_ready;

  assign bus.in_ready   = inReady;
  assign bus.out_valid  = s2Valid;
  assign bus.out_word   = s2Word;
  assign bus.out_mode   = s2Mode;
  assign bus.out_corr   = s2Corr;
  assign bus.out_uncorr = s2Uncorr;

  hamming_core #(
    .DATA_W (DATA_W),
    .SECDED (SECDED)
  ) uCore (
    .rawMode   (bus.in_mode),
    .rawWord   (bus.in_word),
    .stageWord (stageWord),
    .stageSyn  (stageSyn),
    .stageG    (stageG),
    .s1Mode    (s1Mode),
    .s1Word    (s1Word),
    .s1Syn     (s1Syn),
    .s1G       (s1G),
    .resWord   (resWord),
    .resCorr   (resCorr),
    .resUncorr (resUncorr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Mode  <= 1'b0;
      s1Word  <= '0;
      s1Syn   <= '0;
      s1G     <= 1'b0;
    end else if (inXfer) begin
      s1Valid <= 1'b1;
      s1Mode  <= bus.in_mode;
      s1Word  <= stageWord;
      s1Syn   <= stageSyn;
      s1G     <= stageG;
    end else if (s1Advance) begin
      s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid  <= 1'b0;
      s2Mode   <= 1'b0;
      s2Word   <= '0;
      s2Corr   <= 1'b0;
      s2Uncorr <= 1'b0;
    end else if (s2Load) begin
      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Mode   <= s1Mode;
        s2Word   <= resWord;
        s2Corr   <= resCorr;
        s2Uncorr <= resUncorr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else begin
      if (outXfer && s2Corr && (cnt_corr != '1)) cnt_corr <= cnt_corr + 1'b1;
      if (outXfer && s2Uncorr && (cnt_uncorr != '1)) cnt_uncorr <= cnt_uncorr + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_codec_pipe.sv
module tb_hamming_codec_pipe;
  localparam int NR = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clrA = 1'b0;
  logic [15:0] cntCorrA, cntUncorrA, cntCorrB, cntUncorrB;
  logic [1:0]  cntCorrC, cntUncorrC;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_codec_pipe_if #(.CODE_W(13)) ifA ();
  hamming_codec_pipe_if #(.CODE_W(12)) ifB ();
  hamming_codec_pipe_if #(.CODE_W(13)) ifC ();

  // C sees exactly A's traffic; only its counter width differs.
  assign ifC.in_valid  = ifA.in_valid;
  assign ifC.in_mode   = ifA.in_mode;
  assign ifC.in_word   = ifA.in_word;
  assign ifC.out_ready = ifA.out_ready;

  hamming_codec_pipe #(.DATA_W(8), .SECDED(1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .bus(ifA), .cnt_clear(clrA),
    .cnt_corr(cntCorrA), .cnt_uncorr(cntUncorrA));
  hamming_codec_pipe #(.DATA_W(8), .SECDED(0), .CNT_W(16)) dutB (
    .clk(clk), .rst(rst), .bus(ifB), .cnt_clear(1'b0),
    .cnt_corr(cntCorrB), .cnt_uncorr(cntUncorrB));
  hamming_codec_pipe #(.DATA_W(8), .SECDED(1), .CNT_W(2)) dutC (
    .clk(clk), .rst(rst), .bus(ifC), .cnt_clear(clrA),
    .cnt_corr(cntCorrC), .cnt_uncorr(cntUncorrC));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] modelEnc(input logic [7:0] d);
    logic pos [1:12];
    logic [12:0] w;
    logic par;
    int di;
    di = 7;
    for (int p = 1; p <= 12; p++) begin
      if (p == 1 || p == 2 || p == 4 || p == 8) pos[p] = 1'b0;
      else begin
        pos[p] = d[di];
        di--;
      end
    end
    for (int k = 0; k < 4; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++) if (((p >> k) & 1) == 1) par ^= pos[p];
      pos[1 << k] = par;
    end
    w = '0;
    for (int p = 1; p <= 12; p++) w[13-p] = pos[p];
    w[0] = ^w[12:1];
    return w;
  endfunction

  function automatic logic [7:0] modelData(input logic [12:0] w);
    logic [7:0] d;
    int di;
    di = 7;
    d = '0;
    for (int p = 1; p <= 12; p++) begin
      if (!(p == 1 || p == 2 || p == 4 || p == 8)) begin
        d[di] = w[13-p];
        di--;
      end
    end
    return d;
  endfunction

  task automatic runA(input logic mode, input logic [12:0] word, input logic [12:0] expW,
                      input logic expC, input logic expU, input logic clr, input string tag);
    @(negedge clk);
    ifA.in_valid = 1'b1; ifA.in_mode = mode; ifA.in_word = word; ifA.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ifA.in_valid = 1'b0;
    chk({tag, " early_valid"}, 64'(ifA.out_valid), 64'(0));
    @(posedge clk); @(negedge clk);
    chk({tag, " valid"}, 64'(ifA.out_valid), 64'(1));
    chk({tag, " word"}, 64'(ifA.out_word), 64'(expW));
    chk({tag, " mode"}, 64'(ifA.out_mode), 64'(mode));
    chk({tag, " corr"}, 64'(ifA.out_corr), 64'(expC));
    chk({tag, " uncorr"}, 64'(ifA.out_uncorr), 64'(expU));
    clrA = clr;
    @(posedge clk); @(negedge clk);
    clrA = 1'b0;
  endtask

  task automatic runB(input logic mode, input logic [11:0] word, input logic [11:0] expW,
                      input logic expC, input logic expU, input string tag);
    @(negedge clk);
    ifB.in_valid = 1'b1; ifB.in_mode = mode; ifB.in_word = word; ifB.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ifB.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, " valid"}, 64'(ifB.out_valid), 64'(1));
    chk({tag, " word"}, 64'(ifB.out_word), 64'(expW));
    chk({tag, " corr"}, 64'(ifB.out_corr), 64'(expC));
    chk({tag, " uncorr"}, 64'(ifB.out_uncorr), 64'(expU));
    @(posedge clk); @(negedge clk);
  endtask

  logic [12:0] stW [NR];
  logic [12:0] exW [NR];
  logic        stM [NR];
  logic        exC [NR];
  logic        exU [NR];

  initial begin
    logic [12:0] cw, recv, prevWord;
    logic [7:0]  d;
    int nerr, b1, b2, sent, rcvd, idx, modelCorr, modelUncorr;
    logic prevStall;

    ifA.in_valid = 1'b0; ifA.in_mode = 1'b0; ifA.in_word = '0; ifA.out_ready = 1'b0;
    ifB.in_valid = 1'b0; ifB.in_mode = 1'b0; ifB.in_word = '0; ifB.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(ifA.out_valid), 64'(0));
    chk("rst out_word", 64'(ifA.out_word), 64'(0));
    chk("rst in_ready", 64'(ifA.in_ready), 64'(1));
    chk("rst cnt_corr", 64'(cntCorrA), 64'(0));
    rst = 1'b0;

    runA(1'b0, 13'h003B, 13'b1101011110111, 1'b0, 1'b0, 1'b0, "enc 3B");
    runA(1'b0, 13'h0049, 13'b0000100010011, 1'b0, 1'b0, 1'b0, "enc 49");
    runA(1'b1, 13'b1101001110111, 13'h003B, 1'b1, 1'b0, 1'b0, "dec pos6");
    chk("cnt_corr after pos6", 64'(cntCorrA), 64'(1));
    chk("cnt_corr C after pos6", 64'(cntCorrC), 64'(1));
    runA(1'b1, 13'b0101011110111 ^ 13'b0010000000000, 13'h00BB, 1'b0, 1'b1, 1'b0, "dec double");
    chk("cnt_uncorr after double", 64'(cntUncorrA), 64'(1));
    runA(1'b1, 13'b1101011110111, 13'h003B, 1'b0, 1'b0, 1'b0, "dec clean");
    runA(1'b1, 13'b1101011110110, 13'h003B, 1'b1, 1'b0, 1'b0, "dec pos0");
    for (int i = 1; i <= 5; i++)
      runA(1'b1, 13'b1101011110111 ^ (13'h1 << (13 - i)), 13'h003B, 1'b1, 1'b0, 1'b0, "dec burst");
    chk("cnt_corr after burst", 64'(cntCorrA), 64'(7));
    chk("cnt_corr C saturated", 64'(cntCorrC), 64'(3));
    chk("cnt_uncorr C", 64'(cntUncorrC), 64'(1));
    runA(1'b1, 13'b1101011110101, 13'h003B, 1'b1, 1'b0, 1'b1, "dec with clear");
    chk("cnt_corr cleared", 64'(cntCorrA), 64'(0));
    chk("cnt_uncorr cleared", 64'(cntUncorrA), 64'(0));
    chk("cnt_corr C cleared", 64'(cntCorrC), 64'(0));

    runB(1'b0, 12'h03B, 12'b110101111011, 1'b0, 1'b0, "B enc 3B");
    runB(1'b1, 12'b110101111010, 12'h03B, 1'b1, 1'b0, "B dec pos12");
    runB(1'b1, 12'b010101111010, 12'h03A, 1'b0, 1'b1, "B dec syn13");
    chk("B cnt_corr", 64'(cntCorrB), 64'(1));
    chk("B cnt_uncorr", 64'(cntUncorrB), 64'(1));

    for (int i = 0; i < NR; i++) begin
      d  = 8'($urandom);
      cw = modelEnc(d);
      stM[i] = 1'($urandom_range(0, 1));
      if (!stM[i]) begin
        stW[i] = {5'b0, d}; exW[i] = cw; exC[i] = 1'b0; exU[i] = 1'b0;
      end else begin
        nerr = $urandom_range(0, 2);
        b1 = $urandom_range(0, 12);
        b2 = (b1 + 1 + $urandom_range(0, 11)) % 13;
        recv = cw;
        if (nerr >= 1) recv[b1] = ~recv[b1];
        if (nerr == 2) recv[b2] = ~recv[b2];
        stW[i] = recv;
        exW[i] = (nerr == 2) ? {5'b0, modelData(recv)} : {5'b0, d};
        exC[i] = (nerr == 1);
        exU[i] = (nerr == 2);
      end
    end

    sent = 0; rcvd = 0; prevStall = 1'b0; prevWord = '0;
    modelCorr = 0; modelUncorr = 0;
    for (int cyc = 0; cyc < 600 && rcvd < NR; cyc++) begin
      @(negedge clk);
      if (prevStall) begin
        chk("stall hold valid", 64'(ifA.out_valid), 64'(1));
        chk("stall hold word", 64'(ifA.out_word), 64'(prevWord));
      end
      idx = (sent < NR) ? sent : 0;
      ifA.out_ready = 1'($urandom_range(0, 1));
      ifA.in_valid  = (sent < NR) && ($urandom_range(0, 3) != 0);
      ifA.in_mode   = stM[idx];
      ifA.in_word   = stW[idx];
      #1;
      if (ifA.in_valid && ifA.in_ready) sent++;
      if (ifA.out_valid && ifA.out_ready) begin
        chk("rand word", 64'(ifA.out_word), 64'(exW[rcvd]));
        chk("rand mode", 64'(ifA.out_mode), 64'(stM[rcvd]));
        chk("rand flags", 64'({ifA.out_corr, ifA.out_uncorr}), 64'({exC[rcvd], exU[rcvd]}));
        if (exC[rcvd]) modelCorr++;
        if (exU[rcvd]) modelUncorr++;
        rcvd++;
      end
      prevStall = ifA.out_valid && !ifA.out_ready;
      prevWord  = ifA.out_word;
    end
    chk("rand all received", 64'(rcvd), 64'(NR));
    @(negedge clk);
    ifA.in_valid = 1'b0; ifA.out_ready = 1'b1;
    chk("rand cnt_corr", 64'(cntCorrA), 64'(modelCorr));
    chk("rand cnt_uncorr", 64'(cntUncorrA), 64'(modelUncorr));
    chk("rand cnt_corr C", 64'(cntCorrC), 64'((modelCorr > 3) ? 3 : modelCorr));

    ifA.out_ready = 1'b0;
    ifA.in_valid = 1'b1; ifA.in_mode = 1'b1; ifA.in_word = 13'b1101001110111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    ifA.in_valid = 1'b0;
    chk("midrst out_valid", 64'(ifA.out_valid), 64'(0));
    chk("midrst out_word", 64'(ifA.out_word), 64'(0));
    chk("midrst flags", 64'({ifA.out_mode, ifA.out_corr, ifA.out_uncorr}), 64'(0));
    chk("midrst counters", 64'({cntCorrA, cntUncorrA}), 64'(0));
    chk("midrst counters C", 64'({cntCorrC, cntUncorrC, ifC.out_valid}), 64'(0));
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post rst out_valid", 64'(ifA.out_valid), 64'(0));
    runA(1'b0, 13'h0049, 13'b0000100010011, 1'b0, 1'b0, 1'b0, "post rst enc");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
